data_sram_responder: RTL and testbench

//  Slave end of the SRAM-like data bus driven by the EX stage (req/wr/size/addr/wstrb/wdata,

---
 rtl/data_sram_responder_pkg.sv | 36 +++
 rtl/data_sram_resp_queue.sv | 71 +++++++
 rtl/data_sram_responder.sv | 89 ++++++++
 tb/tb_data_sram_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared types for the data-side SRAM responder: size encoding, bus widths,
// queue entry layout and the byte-lane write merge.
package data_sram_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CD_W   = 4;

    // Size encoding shared with EX/ME; the responder itself never uses it for lane selection.
    typedef enum logic [1:0] {
        SzByte = 2'b00,
        SzHalf = 2'b01,
        SzWord = 2'b10,
        SzRsvd = 2'b11
    } size_e;

    typedef struct packed {
        logic              wr;
        logic [DATA_W-1:0] rdata;
    } resp_entry_t;

    function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_word,
                                                      input logic [DATA_W-1:0] new_word,
                                                      input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_resp_queue.sv
// In-order outstanding-request queue: circular buffer with a per-entry latency
// countdown; the head may respond once its countdown has reached zero.
module data_sram_resp_queue
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  resp_entry_t push_entry,
    input  logic        pop_en,
    output logic        head_ready,
    output resp_entry_t head_entry,
    output logic        full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CD_W-1:0] CD_INIT = CD_W'(LATENCY - 1);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   count_q;
    resp_entry_t      entry_q [DEPTH];
    logic [CD_W-1:0]  cd_q    [DEPTH];
    logic             pop;

    assign head_ready = (count_q != '0) && (cd_q[head_q] == '0);
    assign pop        = head_ready & pop_en;
    assign head_entry = entry_q[head_q];
    assign full       = (count_q == FULL_COUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                cd_q[i] <= '0;
            end
        end else begin
            // Free slots sit at zero, so decrementing every nonzero counter is safe.
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (push && (tail_q == PTR_W'(i))) begin
                    cd_q[i] <= CD_INIT;
                end else if (cd_q[i] != '0) begin
                    cd_q[i] <= cd_q[i] - 1'b1;
                end
            end
            if (push) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[tail_q] <= push_entry;
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Slave end of the data SRAM-like bus: word memory, write merge and addr_ok.
// Optional random backpressure when DATA_SRAM_RESP_STALL_EN is defined.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [DATA_W-1:0] wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              accept_en;
    logic              pop_en;
    logic              q_full;
    logic              head_ready;
    resp_entry_t       push_entry;
    resp_entry_t       head_entry;
    size_e             size_dec;
    logic              unused_bits;

    assign idx      = addr[IDX_W+1:2];
    assign size_dec = size_e'(size);
    assign unused_bits = ^{size_dec, addr[ADDR_W-1:IDX_W+2], addr[1:0], head_entry.wr};

`ifdef DATA_SRAM_RESP_STALL_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign accept_en = lfsr_q[0];
    assign pop_en    = lfsr_q[1];
`else
    assign accept_en = 1'b1;
    assign pop_en    = 1'b1;
`endif

    assign addr_ok = ~q_full & accept_en;
    assign accept  = req & addr_ok & ~reset;

    // Combinational read is captured at the edge, so a read sees memory before any same-edge write.
    assign push_entry = '{wr: wr, rdata: (wr ? '0 : mem[idx])};

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem[idx] <= merge_lanes(mem[idx], wdata, wstrb);
        end
    end

    data_sram_resp_queue #(
        .DEPTH   (MAX_OUTSTANDING),
        .LATENCY (LATENCY)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_entry (push_entry),
        .pop_en     (pop_en),
        .head_ready (head_ready),
        .head_entry (head_entry),
        .full       (q_full)
    );

    assign data_ok = head_ready & pop_en;
    assign rdata   = data_ok ? head_entry.rdata : '0;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench: LATENCY=2 instance driven from a vector table, LATENCY=8 instance
// used for queue-full, wrap-around and mid-operation reset sequences.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        rst1, rst2;
    logic        req1, req2;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok1, data_ok1, addr_ok2, data_ok2;
    logic [31:0] rdata1, rdata2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_sram_responder #(
        .MEM_WORDS       (1024),
        .LATENCY         (2),
        .MAX_OUTSTANDING (4)
    ) u_dut (
        .clk     (clk),
        .reset   (rst1),
        .req     (req1),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wstrb   (wstrb),
        .wdata   (wdata),
        .addr_ok (addr_ok1),
        .data_ok (data_ok1),
        .rdata   (rdata1)
    );

    data_sram_responder #(
        .MEM_WORDS       (1024),
        .LATENCY         (8),
        .MAX_OUTSTANDING (4)
    ) u_dut_l8 (
        .clk     (clk),
        .reset   (rst2),
        .req     (req2),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wstrb   (wstrb),
        .wdata   (wdata),
        .addr_ok (addr_ok2),
        .data_ok (data_ok2),
        .rdata   (rdata2)
    );

    typedef struct {
        logic        req;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        exp_aok;
        logic        exp_dok;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int dok_seen;
        logic exp_aok, exp_dok;

        rst1 = 1'b1; rst2 = 1'b1;
        req1 = 1'b0; req2 = 1'b0;
        wr = 1'b0; size = 2'b10; addr = '0; wstrb = '0; wdata = '0;

        // Reset held 3 cycles, then idle.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_addr_ok", addr_ok1, 1);
            chk("rst_data_ok", data_ok1, 0);
            chk("rst_rdata", rdata1, 0);
            chk("rst_addr_ok_l8", addr_ok2, 1);
            chk("rst_data_ok_l8", data_ok2, 0);
        end
        rst1 = 1'b0; rst2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_data_ok", data_ok1, 0);
            chk("idle_data_ok_l8", data_ok2, 0);
        end

        // Expected outputs are those visible in the same cycle, before the edge that takes the inputs.
        vecs[0]  = '{1, 1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1, 0, 32'h0};
        vecs[1]  = '{1, 0, 32'h0000_0010, 4'h0, 32'h0,         1, 0, 32'h0};
        vecs[2]  = '{1, 1, 32'h0000_0020, 4'hF, 32'h1122_3344, 1, 1, 32'h0};
        vecs[3]  = '{1, 1, 32'h0000_0021, 4'h2, 32'h0000_AA00, 1, 1, 32'hDEAD_BEEF};
        vecs[4]  = '{1, 0, 32'h0000_0020, 4'h0, 32'h0,         1, 1, 32'h0};
        vecs[5]  = '{1, 1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1, 1, 32'h0};
        vecs[6]  = '{1, 0, 32'h0000_1000, 4'h0, 32'h0,         1, 1, 32'h1122_AA44};
        vecs[7]  = '{1, 0, 32'h0000_0010, 4'hF, 32'h1234_5678, 1, 1, 32'h0};
        vecs[8]  = '{1, 0, 32'h0000_1010, 4'h0, 32'h0,         1, 1, 32'hCAFE_F00D};
        vecs[9]  = '{0, 0, 32'h0,         4'h0, 32'h0,         1, 1, 32'hDEAD_BEEF};
        vecs[10] = '{0, 0, 32'h0,         4'h0, 32'h0,         1, 1, 32'hDEAD_BEEF};
        vecs[11] = '{0, 0, 32'h0,         4'h0, 32'h0,         1, 0, 32'h0};

        for (int i = 0; i < 12; i++) begin
            req1  = vecs[i].req;
            wr    = vecs[i].wr;
            addr  = vecs[i].addr;
            wstrb = vecs[i].wstrb;
            wdata = vecs[i].wdata;
            chk($sformatf("vec%0d_addr_ok", i), addr_ok1, vecs[i].exp_aok);
            chk($sformatf("vec%0d_data_ok", i), data_ok1, vecs[i].exp_dok);
            chk($sformatf("vec%0d_rdata", i), rdata1, vecs[i].exp_rdata);
            step();
        end
        req1 = 1'b0;

        // Preload words 0..5 of the LATENCY=8 instance, draining between writes.
        for (int k = 0; k < 6; k++) begin
            req2 = 1'b1; wr = 1'b1; addr = 32'(k) << 2; wstrb = 4'hF; wdata = 32'h5000_0000 + 32'(k);
            chk("preload_addr_ok", addr_ok2, 1);
            step();
            req2 = 1'b0; wr = 1'b0; wstrb = 4'h0;
            repeat (9) step();
        end

        // Queue full: req held for 6 reads; 4 accepts at steps 0..3, first pop at step 8.
        accepted = 0;
        dok_seen = 0;
        for (int s = 0; s < 22; s++) begin
            req2 = (accepted < 6);
            wr   = 1'b0;
            addr = 32'(accepted) << 2;
            exp_aok = (s < 4) || (s >= 9);
            exp_dok = (s >= 8 && s <= 11) || s == 17 || s == 18;
            chk("full_addr_ok", addr_ok2, exp_aok);
            chk("full_data_ok", data_ok2, exp_dok);
            if (data_ok2 && exp_dok) begin
                chk("full_rdata", rdata2, 32'h5000_0000 + 32'(dok_seen));
                dok_seen++;
            end
            if (req2 && addr_ok2) accepted++;
            step();
        end
        req2 = 1'b0;
        chk("full_responses", dok_seen, 6);

        // Reset with 3 reads outstanding.
        for (int k = 0; k < 3; k++) begin
            req2 = 1'b1; wr = 1'b0; addr = 32'(k) << 2;
            step();
        end
        req2 = 1'b0;
        rst2 = 1'b1;
        step();
        step();
        rst2 = 1'b0;
        for (int s = 0; s < 12; s++) begin
            chk("midrst_data_ok", data_ok2, 0);
            chk("midrst_addr_ok", addr_ok2, 1);
            step();
        end

        // Count must be 0 again: 4 more accepts before addr_ok drops; memory kept across reset.
        accepted = 0;
        for (int s = 0; s < 14; s++) begin
            req2 = (s < 6);
            wr   = 1'b0;
            addr = 32'(accepted) << 2;
            exp_aok = (s < 4) || (s >= 9);
            exp_dok = (s >= 8 && s <= 11);
            chk("postrst_addr_ok", addr_ok2, exp_aok);
            chk("postrst_data_ok", data_ok2, exp_dok);
            if (exp_dok) chk("postrst_rdata", rdata2, 32'h5000_0000 + 32'(s - 8));
            if (req2 && addr_ok2) accepted++;
            step();
        end
        req2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
